crack_host_sequencer: RTL and testbench



---
 rtl/crack_host_sequencer_pkg.sv | 23 ++
 rtl/crack_host_sequencer_if.sv | 23 ++
 rtl/crack_host_sequencer_timer.sv | 26 ++
 rtl/crack_host_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_crack_host_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crack_host_sequencer_pkg.sv
// Shared types and constants for the cracker host sequencer.
package crack_host_pkg;

  localparam int unsigned HASH_BYTES = 16;
  localparam logic [7:0]  DONE_BYTE  = 8'h00;

  typedef enum logic [3:0] {
    GET_COUNT,
    LOAD_WAIT,
    LOAD_STROBE,
    LOAD_SETTLE,
    GO_WAIT,
    GO_STROBE,
    GO_SETTLE,
    RESULT_WAIT,
    READ_CAPTURE,
    READ_EMIT,
    READ_STROBE,
    READ_SETTLE,
    DONE_EMIT
  } state_e;

endpackage

// File: rtl/crack_host_sequencer_if.sv
// Host-side byte streams: command bytes in, result records out.
interface crack_host_sequencer_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_last;
  logic       res_done;

  modport master (
    output cmd_valid, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data, res_last, res_done
  );

  modport slave (
    input  cmd_valid, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data, res_last, res_done
  );

endinterface

// File: rtl/crack_host_sequencer_timer.sv
// Down-counter shared by the strobe and settle phases; expired_c is high at zero.
module crack_strobe_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/crack_host_sequencer.sv
// Drives the cracker core's byte-serial handshake from a host byte stream:
// loads a hash batch, pulses go, and streams back each 21-byte match record.
module crack_host_sequencer
  import crack_host_pkg::*;
#(
  parameter int unsigned MAX_HASHES    = 16,
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned PW_BYTES      = 21
) (
  input  logic                    clk,
  input  logic                    reset,
  crack_host_sequencer_if.slave   host,
  output logic [7:0]              ck_new_hash_byte,
  output logic                    ck_store_hash_byte,
  output logic                    ck_go,
  input  logic                    ck_match_found,
  input  logic                    ck_my_turn,
  input  logic [7:0]              ck_password_byte,
  output logic                    busy,
  output logic                    err_count
);

  localparam int unsigned TMR_MAX = (STROBE_CYCLES > SETTLE_CYCLES) ? STROBE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned BL_W    = $clog2(MAX_HASHES * HASH_BYTES + 1);
  localparam int unsigned IDX_W   = ($clog2(PW_BYTES) > 0) ? $clog2(PW_BYTES) : 1;

  localparam logic [TMR_W-1:0] STROBE_LOAD = TMR_W'(STROBE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PW_BYTES - 1);

  state_e            state_q, state_d;
  logic              turn_meta, turn_s;
  logic [BL_W-1:0]   bytes_left_q, bytes_left_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
  logic              err_d;
  logic [7:0]        hash_byte_d;
  logic [7:0]        res_data_d;
  logic              cmd_ready_d, res_valid_d, res_last_d, res_done_d;
  logic              store_d, go_d, busy_d;
  logic              timer_load;
  logic [TMR_W-1:0]  timer_value;
  logic              timer_exp;
  logic              cmd_acc, res_acc, count_ok;

  crack_strobe_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired_c  (timer_exp)
  );

  // Next-state, datapath updates and registered-output decode
  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    byte_idx_d   = byte_idx_q;
    err_d        = err_count;
    hash_byte_d  = ck_new_hash_byte;
    res_data_d   = host.res_data;
    timer_load   = 1'b0;
    timer_value  = STROBE_LOAD;

    cmd_acc  = host.cmd_valid & host.cmd_ready;
    res_acc  = host.res_valid & host.res_ready;
    count_ok = (host.cmd_data != 8'h00) && (32'(host.cmd_data) <= MAX_HASHES);

    case (state_q)
      GET_COUNT: begin
        if (cmd_acc) begin
          if (count_ok) begin
            bytes_left_d = BL_W'(32'(host.cmd_data) * HASH_BYTES);
            err_d        = 1'b0;
            state_d      = LOAD_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        if (cmd_acc) begin
          hash_byte_d = host.cmd_data;
          state_d     = LOAD_STROBE;
          timer_load  = 1'b1;
        end
      end
      LOAD_STROBE: begin
        if (timer_exp) begin
          state_d     = LOAD_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      LOAD_SETTLE: begin
        if (timer_exp) begin
          bytes_left_d = bytes_left_q - BL_W'(1);
          state_d      = (bytes_left_q == BL_W'(1)) ? GO_WAIT : LOAD_WAIT;
        end
      end
      GO_WAIT: begin
        if (turn_s) begin
          state_d    = GO_STROBE;
          timer_load = 1'b1;
        end
      end
      GO_STROBE: begin
        if (timer_exp) begin
          state_d     = GO_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      GO_SETTLE: begin
        if (timer_exp) begin
          state_d = RESULT_WAIT;
        end
      end
      RESULT_WAIT: begin
        if (turn_s) begin
          if (ck_match_found) begin
            byte_idx_d = '0;
            state_d    = READ_CAPTURE;
          end else begin
            res_data_d = DONE_BYTE;
            state_d    = DONE_EMIT;
          end
        end
      end
      READ_CAPTURE: begin
        res_data_d = ck_password_byte;
        state_d    = READ_EMIT;
      end
      READ_EMIT: begin
        // No go until the sink takes the byte, so the cracker simply stalls.
        if (res_acc) begin
          state_d    = READ_STROBE;
          timer_load = 1'b1;
        end
      end
      READ_STROBE: begin
        if (timer_exp) begin
          state_d     = READ_SETTLE;
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
        end
      end
      READ_SETTLE: begin
        // Timer stays expired at zero, so this also serves as the wait for the next byte.
        if (timer_exp) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = RESULT_WAIT;
          end else if (turn_s) begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            state_d    = READ_CAPTURE;
          end
        end
      end
      DONE_EMIT: begin
        if (res_acc) begin
          state_d = GET_COUNT;
        end
      end
      default: state_d = GET_COUNT;
    endcase

    // turn_meta is next cycle's turn_s, keeping cmd_ready aligned with the state it gates
    cmd_ready_d = (state_d == GET_COUNT) || ((state_d == LOAD_WAIT) && turn_meta);
    res_valid_d = (state_d == READ_EMIT) || (state_d == DONE_EMIT);
    res_last_d  = (state_d == DONE_EMIT) || ((state_d == READ_EMIT) && (byte_idx_d == LAST_IDX));
    res_done_d  = (state_d == DONE_EMIT);
    store_d     = (state_d == LOAD_STROBE);
    go_d        = (state_d == GO_STROBE) || (state_d == READ_STROBE);
    busy_d      = (state_d != GET_COUNT);
  end

  // State, synchronizer, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= GET_COUNT;
      turn_meta          <= 1'b0;
      turn_s             <= 1'b0;
      bytes_left_q       <= '0;
      byte_idx_q         <= '0;
      err_count          <= 1'b0;
      ck_new_hash_byte   <= 8'h00;
      ck_store_hash_byte <= 1'b0;
      ck_go              <= 1'b0;
      busy               <= 1'b0;
      host.cmd_ready     <= 1'b0;
      host.res_valid     <= 1'b0;
      host.res_data      <= 8'h00;
      host.res_last      <= 1'b0;
      host.res_done      <= 1'b0;
    end else begin
      state_q            <= state_d;
      turn_meta          <= ck_my_turn;
      turn_s             <= turn_meta;
      bytes_left_q       <= bytes_left_d;
      byte_idx_q         <= byte_idx_d;
      err_count          <= err_d;
      ck_new_hash_byte   <= hash_byte_d;
      ck_store_hash_byte <= store_d;
      ck_go              <= go_d;
      busy               <= busy_d;
      host.cmd_ready     <= cmd_ready_d;
      host.res_valid     <= res_valid_d;
      host.res_data      <= res_data_d;
      host.res_last      <= res_last_d;
      host.res_done      <= res_done_d;
    end
  end

endmodule

// File: tb/tb_crack_host_sequencer.sv
// Self-checking bench: behavioural cracker stub, host driver and result sink.
module tb_crack_host_sequencer;

  localparam int unsigned MAX_HASHES    = 16;
  localparam int unsigned STROBE_CYCLES = 8;
  localparam int unsigned SETTLE_CYCLES = 8;
  localparam int unsigned PW_BYTES      = 21;
  localparam int BYTE_TIMEOUT = 2000;
  localparam int DONE_TIMEOUT = 6000;
  localparam int S_LOAD = 0, S_SEARCH = 1, S_READ = 2, S_DONE = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       done;
  } res_t;

  typedef struct {
    int unsigned count;
    bit          exp_err;
    int unsigned nrec;
    int unsigned rdiv;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ck_new_hash_byte;
  logic       ck_store_hash_byte, ck_go;
  logic       ck_match_found, ck_my_turn;
  logic [7:0] ck_password_byte;
  logic       busy, err_count;

  crack_host_sequencer_if host ();

  crack_host_sequencer #(
    .MAX_HASHES(MAX_HASHES), .STROBE_CYCLES(STROBE_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES), .PW_BYTES(PW_BYTES)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .host               (host),
    .ck_new_hash_byte   (ck_new_hash_byte),
    .ck_store_hash_byte (ck_store_hash_byte),
    .ck_go              (ck_go),
    .ck_match_found     (ck_match_found),
    .ck_my_turn         (ck_my_turn),
    .ck_password_byte   (ck_password_byte),
    .busy               (busy),
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit abort = 0;

  // cracker stub state
  int         stub_mode = S_LOAD;
  int         stub_delay = 0;
  int         stub_idx = 0;
  logic [7:0] stub_bytes[$];
  logic [7:0] got_hash[$];
  int         n_store = 0, n_go = 0, viol = 0, viol_bp = 0;
  int         store_len = 0, go_len = 0;
  logic       prev_store = 1'b0, prev_go = 1'b0;
  logic [7:0] cap_hash = 8'h00;

  // result sink state
  res_t        got_res[$];
  bit          got_done = 0;
  int unsigned ready_div = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Cracker stub: owns my_turn while strobes are busy, serves queued match records.
  initial begin
    ck_my_turn = 1'b1; ck_match_found = 1'b0; ck_password_byte = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        prev_store = 1'b0; prev_go = 1'b0; store_len = 0; go_len = 0;
      end else begin
        if (ck_store_hash_byte && ck_go) viol++;
        if (ck_store_hash_byte) begin
          if (!prev_store) begin
            n_store++; got_hash.push_back(ck_new_hash_byte); cap_hash = ck_new_hash_byte;
            ck_my_turn = 1'b0; stub_delay = $urandom_range(0, 6);
          end else if (ck_new_hash_byte !== cap_hash) viol++;
          store_len++;
        end else if (prev_store) begin
          if (store_len != STROBE_CYCLES) viol++;
          store_len = 0;
        end
        if (ck_go) begin
          if (!prev_go) begin
            n_go++; ck_my_turn = 1'b0; stub_delay = $urandom_range(0, 6);
            if (stub_mode == S_LOAD) begin
              stub_mode = S_SEARCH; stub_delay = $urandom_range(3, 25);
            end else if (stub_mode == S_READ) begin
              void'(stub_bytes.pop_front());
              stub_idx++;
              if (stub_idx == PW_BYTES) begin
                stub_mode = S_SEARCH; stub_delay = $urandom_range(3, 25);
              end
            end
          end
          go_len++;
        end else if (prev_go) begin
          if (go_len != STROBE_CYCLES) viol++;
          go_len = 0;
        end
        prev_store = ck_store_hash_byte;
        prev_go    = ck_go;
        if (!ck_my_turn && !ck_store_hash_byte && !ck_go) begin
          if (stub_delay > 0) stub_delay--;
          else begin
            if (stub_mode == S_SEARCH) begin
              if (stub_bytes.size() > 0) begin stub_mode = S_READ; stub_idx = 0; end
              else stub_mode = S_DONE;
            end
            if (stub_mode == S_READ) ck_password_byte = stub_bytes[0];
            ck_my_turn = 1'b1;
          end
        end
        ck_match_found = (stub_mode == S_READ);
      end
    end
  end

  // Result sink with randomized backpressure; handshake sampled mid-cycle.
  initial begin
    host.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ck_go && host.res_valid && !host.res_ready) viol_bp++;
      if (!reset && host.res_valid && host.res_ready) begin
        got_res.push_back('{host.res_data, host.res_last, host.res_done});
        if (host.res_done) got_done = 1;
      end
      @(posedge clk); #2;
      host.res_ready = ($urandom_range(0, ready_div - 1) == 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 0;
    host.cmd_valid = 1'b1;
    host.cmd_data  = b;
    for (int t = 0; t < BYTE_TIMEOUT; t++) begin
      @(negedge clk);
      if (host.cmd_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    host.cmd_valid = 1'b0;
  endtask

  task automatic stub_restart();
    got_res.delete(); got_hash.delete(); stub_bytes.delete();
    got_done = 0; viol = 0; viol_bp = 0; n_store = 0; n_go = 0;
    stub_mode = S_LOAD; ck_match_found = 1'b0; ck_my_turn = 1'b1;
  endtask

  // kind: 0 random data, 1 reference hashes/passwords, 2 ramp record 01..15
  task automatic run_batch(input int unsigned count, input bit exp_err, input int unsigned nrec,
                           input int unsigned rdiv, input int kind);
    logic [127:0] h;
    logic [7:0]   rb;
    logic [7:0]   exp_hash[$];
    res_t         exp_res[$];
    bit           ok;
    int           mism;
    ready_div = rdiv;
    stub_restart();
    for (int r = 0; r < int'(nrec); r++) begin
      for (int k = 0; k < int'(PW_BYTES); k++) begin
        rb = 8'($urandom);
        if (kind == 2) rb = 8'(k + 1);
        if (kind == 1) begin
          if (k == int'(PW_BYTES) - 1) rb = 8'h02;
          else if (k == 0)            rb = (r == 0) ? 8'h31 : 8'h21;
          else if (k == 1)            rb = (r == 0) ? 8'h32 : 8'h3F;
          else                        rb = 8'h00;
        end
        stub_bytes.push_back(rb);
        exp_res.push_back('{rb, (k == int'(PW_BYTES) - 1), 1'b0});
      end
    end
    exp_res.push_back('{8'h00, 1'b1, 1'b1});
    send_byte(8'(count), ok);
    check("count_accept", 64'(ok), 64'd1);
    if (!ok) begin abort = 1; return; end
    if (exp_err) begin
      repeat (3) @(posedge clk); #1;
      check("err_count_set", 64'(err_count), 64'd1);
      check("cmd_ready_after_err", 64'(host.cmd_ready), 64'd1);
      check("no_strobes_after_err", 64'(n_store + n_go), 64'd0);
      return;
    end
    check("err_count_clear", 64'(err_count), 64'd0);
    for (int i = 0; i < int'(count); i++) begin
      h = {$urandom, $urandom, $urandom, $urandom};
      if (kind == 1) h = (i == 0) ? 128'h588FEB889288FB953B5F094D47D1565C
                                  : 128'h91D533DC611AC2774431E2D0BAF36805;
      for (int b = 0; b < 16; b++) exp_hash.push_back(h[8*b +: 8]);
    end
    foreach (exp_hash[i]) begin
      send_byte(exp_hash[i], ok);
      if (!ok) begin check("hash_byte_accept", 64'(i), 64'(exp_hash.size())); abort = 1; return; end
    end
    for (int t = 0; t < DONE_TIMEOUT && !got_done; t++) @(posedge clk);
    check("done_record_seen", 64'(got_done), 64'd1);
    if (!got_done) abort = 1;
    repeat (3) @(posedge clk); #1;
    check("busy_idle", 64'(busy), 64'd0);
    check("cmd_ready_idle", 64'(host.cmd_ready), 64'd1);
    check("store_strobes", 64'(n_store), 64'(count * 16));
    check("go_strobes", 64'(n_go), 64'(1 + nrec * PW_BYTES));
    check("strobe_rules", 64'(viol), 64'd0);
    check("go_under_backpressure", 64'(viol_bp), 64'd0);
    check("hash_count", 64'(got_hash.size()), 64'(exp_hash.size()));
    mism = 0;
    foreach (exp_hash[i]) if (i < got_hash.size() && got_hash[i] !== exp_hash[i]) mism++;
    check("hash_bytes", 64'(mism), 64'd0);
    check("res_count", 64'(got_res.size()), 64'(exp_res.size()));
    mism = 0;
    foreach (exp_res[i]) if (i < got_res.size() && got_res[i] !== exp_res[i]) mism++;
    check("res_stream", 64'(mism), 64'd0);
    if (kind == 1 && got_hash.size() == 32) begin
      check("first_hash_byte", 64'(got_hash[0]), 64'h5C);
      check("last_hash_byte", 64'(got_hash[31]), 64'h91);
    end
  endtask

  vec_t vecs[6];

  initial begin
    bit ok;
    vecs[0] = '{0,   1'b1, 0, 1};
    vecs[1] = '{17,  1'b1, 0, 1};
    vecs[2] = '{255, 1'b1, 0, 1};
    vecs[3] = '{1,   1'b0, 0, 1};
    vecs[4] = '{3,   1'b0, 2, 3};
    vecs[5] = '{16,  1'b0, 1, 2};

    reset = 1'b1;
    host.cmd_valid = 1'b0;
    host.cmd_data  = 8'h00;
    repeat (3) @(posedge clk); #1;
    check("reset_values", 64'({ck_store_hash_byte, ck_go, host.cmd_ready, host.res_valid,
          host.res_last, host.res_done, host.res_data, busy, err_count, ck_new_hash_byte}), 64'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("idle_cmd_ready", 64'(host.cmd_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    foreach (vecs[i]) if (!abort) run_batch(vecs[i].count, vecs[i].exp_err, vecs[i].nrec, vecs[i].rdiv, 0);
    if (!abort) run_batch(2, 1'b0, 2, 1, 1);
    if (!abort) run_batch(1, 1'b0, 1, 3, 2);

    // abort a load mid-strobe on the eighth hash byte
    if (!abort) begin
      stub_restart();
      send_byte(8'd1, ok);
      for (int i = 0; i < 8 && ok; i++) send_byte(8'(8'hA0 + i), ok);
      check("partial_load_accept", 64'(ok), 64'd1);
      for (int t = 0; t < 50 && !ck_store_hash_byte; t++) @(negedge clk);
      check("store_before_reset", 64'(n_store), 64'd8);
      @(negedge clk); #2;
      reset = 1'b1; #1;
      check("async_reset_outputs", 64'({ck_store_hash_byte, ck_go, host.cmd_ready, host.res_valid,
            host.res_last, host.res_done, host.res_data, busy, err_count, ck_new_hash_byte}), 64'd0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      run_batch(1, 1'b0, 0, 2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
